// File: rtl/instr_encoder.sv
// Instruction word encoder (I/B/J immediate formats) feeding a small output FIFO.
// Each entry holds the encoded word plus an error flag; err_cnt tallies accepted error beats.
module instr_encoder #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_sel,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_B = 3'b001,
        IMM_J = 3'b010
    } imm_fmt_e;

    logic [31:0]   enc_instr;
    logic          enc_err;
    logic [31:0]   mem_instr [DEPTH];
    logic          mem_err   [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Range errors still produce the truncated encoding; only illegal formats force zero.
    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b1;
        case (imm_fmt_e'(imm_sel))
            IMM_I: begin
                enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err   = !((&imm[31:11]) || (~|imm[31:11]));
            end
            IMM_B: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err   = !((&imm[31:12]) || (~|imm[31:12])) || imm[0];
            end
            IMM_J: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err   = !((&imm[31:20]) || (~|imm[31:20])) || imm[0];
            end
            default: begin
                enc_instr = '0;
                enc_err   = 1'b1;
            end
        endcase
    end

    // in_ready comes only from count, so a full FIFO never pushes in the cycle it pops.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && enc_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_instr[wptr] <= enc_instr;
            mem_err[wptr]   <= enc_err;
        end
    end

    assign instr = out_valid ? mem_instr[rptr] : '0;
    assign err   = out_valid ? mem_err[rptr]   : 1'b0;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=2): encodings, error flags,
// backpressure ordering, err_cnt saturation and mid-operation reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_sel;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [7:0]  err_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    instr_encoder #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_sel   (imm_sel),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] a, input logic [4:0] b, input logic [2:0] f,
                         input logic [31:0] im);
        imm_sel = s;
        opcode  = op;
        rd      = d;
        rs1     = a;
        rs2     = b;
        funct3  = f;
        imm     = im;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // One beat through an empty FIFO: visible one cycle after acceptance, then popped.
    task automatic send_check(input string tag, input logic [31:0] exp_instr, input logic exp_err);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, instr, exp_instr);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        tick();
        check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_instr",     instr,              32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        check("rst_err_cnt",   {24'd0, err_cnt},   32'd0);

        drive(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        send_check("addi5", 32'h00500093, 1'b0);

        drive(3'b001, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8);
        send_check("beq_m8", 32'hFE208CE3, 1'b0);

        drive(3'b010, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
        send_check("jal_800", 32'h001000EF, 1'b0);

        check("errcnt_before", {24'd0, err_cnt}, 32'd0);
        drive(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        send_check("addi2048", 32'h80000093, 1'b1);
        check("errcnt_after_i", {24'd0, err_cnt}, 32'd1);

        drive(3'b001, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
        send_check("b_odd", 32'h00000163, 1'b1);
        check("errcnt_after_b", {24'd0, err_cnt}, 32'd2);

        drive(3'b111, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 32'd4);
        send_check("bad_sel", 32'h00000000, 1'b1);
        check("errcnt_after_sel", {24'd0, err_cnt}, 32'd3);

        // Backpressure: three beats against a two-entry FIFO with out_ready low.
        do_reset();
        out_ready = 1'b0;
        drive(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
        in_valid = 1'b1;
        check("bp_ready_a", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_head_a", instr, 32'h00100093);
        drive(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2);
        check("bp_ready_b", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_full", {31'd0, in_ready}, 32'd0);
        drive(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
        tick();
        check("bp_hold_a", instr, 32'h00100093);
        check("bp_still_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("bp_head_b", instr, 32'h00200093);
        check("bp_space", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_head_c", instr, 32'h00300093);
        check("bp_c_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("bp_empty", {31'd0, out_valid}, 32'd0);
        check("bp_errcnt", {24'd0, err_cnt}, 32'd0);

        // err_cnt saturation with a continuous stream of illegal-format beats.
        do_reset();
        out_ready = 1'b1;
        drive(3'b111, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        check("sat_254", {24'd0, err_cnt}, 32'h0FE);
        tick();
        check("sat_255", {24'd0, err_cnt}, 32'h0FF);
        tick();
        check("sat_256", {24'd0, err_cnt}, 32'h0FF);
        for (int i = 0; i < 10; i++) tick();
        check("sat_hold", {24'd0, err_cnt}, 32'h0FF);
        in_valid = 1'b0;
        tick();

        // Reset with two buffered entries and a beat presented during reset.
        do_reset();
        out_ready = 1'b0;
        drive(3'b111, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        in_valid = 1'b1;
        tick();
        tick();
        check("mr_errcnt_pre", {24'd0, err_cnt}, 32'd2);
        check("mr_valid_pre", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        drive(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd7);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        check("mr_instr", instr, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_emit", {31'd0, out_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 2, giving the output buffer depth in entries (legal values 2..4).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: the request beat is valid.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-006 The block SHALL have the port imm_sel, input, 3 bits: format select, using the shared encodings IMM_I=3'b000, IMM_B=3'b001, IMM_J=3'b010; all other values are illegal.
REQ-007 The block SHALL have the ports opcode (7 bits), rd (5 bits), rs1 (5 bits), rs2 (5 bits) and funct3 (3 bits), all inputs, carrying the instruction fields.
REQ-008 The block SHALL have the port imm, input, 32 bits: the signed byte-offset immediate, two's complement.
REQ-009 The block SHALL have the port out_valid, output, 1 bit: the output beat is valid.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts the output beat.
REQ-011 The block SHALL have the port instr, output, 32 bits: the encoded instruction word.
REQ-012 The block SHALL have the port err, output, 1 bit: the beat on instr had an unrepresentable immediate or an illegal imm_sel.
REQ-013 The block SHALL have the port err_cnt, output, 8 bits: the count of accepted error beats, saturating.

Function
REQ-014 A beat SHALL be accepted when in_valid and in_ready are both 1, and popped when out_valid and out_ready are both 1.
REQ-015 IMM_I encoding SHALL be instr = {imm[11:0], rs1, funct3, rd, opcode}, with rs2 ignored.
REQ-016 IMM_B encoding SHALL be instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}, with rd ignored.
REQ-017 IMM_J encoding SHALL be instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}, with rs1, rs2 and funct3 ignored.
REQ-018 The error condition for IMM_I SHALL be imm[31:11] not all-equal.
REQ-019 The error condition for IMM_B SHALL be imm[31:12] not all-equal or imm[0]=1.
REQ-020 The error condition for IMM_J SHALL be imm[31:20] not all-equal or imm[0]=1.
REQ-021 On a range error, instr SHALL still carry the truncated encoding and err SHALL be 1.
REQ-022 For an illegal imm_sel, instr SHALL be 32'h0000_0000 and err SHALL be 1.
REQ-023 Encoding and error check SHALL be combinational on the input beat, and the result {instr, err} SHALL be written into a DEPTH-entry FIFO.
REQ-024 Latency SHALL be 1 cycle: a beat accepted in cycle N, with the FIFO empty, is presented on the outputs in cycle N+1.
REQ-025 in_ready SHALL be (count != DEPTH), derived from registered state only, and SHALL NOT depend on out_ready in the same cycle.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-027 When the FIFO is full and a pop occurs, no push SHALL happen in that cycle.
REQ-028 While out_valid=1 and out_ready=0, instr and err SHALL hold stable.
REQ-029 When out_valid=0, instr SHALL be 32'h0 and err SHALL be 0.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 err_cnt SHALL increment by 1 on each accepted beat whose err=1.
REQ-032 err_cnt SHALL saturate at 8'hFF and SHALL NOT wrap.
REQ-033 The FIFO SHALL be pointer-and-count based, and no input beat SHALL be dropped or duplicated.

Reset
REQ-034 While rst_n=0 at a clock edge, the block SHALL clear count, pointers and err_cnt.
REQ-035 In the cycle after reset, out_valid=0, in_ready=1, instr=0, err=0 and err_cnt=0 SHALL hold.
REQ-036 Reset asserted mid-operation SHALL discard all buffered entries, and any beat presented during reset SHALL NOT be accepted.

Verification
REQ-037 The bench SHALL check: IMM_I, opcode=7'h13, rd=1, rs1=0, funct3=0, imm=5 -> instr=32'h00500093, err=0, one cycle later.
REQ-038 The bench SHALL check: IMM_B, opcode=7'h63, rs1=1, rs2=2, funct3=0, imm=-8 -> instr=32'hFE208CE3, err=0.
REQ-039 The bench SHALL check: IMM_J, opcode=7'h6F, rd=1, imm=32'h800 -> instr=32'h001000EF, err=0.
REQ-040 The bench SHALL check: IMM_I addi with imm=2048 -> instr=32'h80000093, err=1, err_cnt 0->1.
REQ-041 The bench SHALL check: IMM_B with imm=3 -> err=1.
REQ-042 The bench SHALL check: imm_sel=3'b111 -> instr=0, err=1.
REQ-043 The bench SHALL check: out_ready=0 with 3 back-to-back beats (DEPTH=2) -> in_ready=0 after 2 accepts; raising out_ready drains the beats in order and the third is accepted once space frees.
REQ-044 The bench SHALL check: 256 error beats -> err_cnt=8'hFF and it holds there.
REQ-045 The bench SHALL check: rst_n=0 for one cycle while 2 entries are buffered -> out_valid=0 and err_cnt=0 the next cycle, with nothing emitted afterwards.
